if_pc_redirect: RTL and testbench

- IF-stage PC sequencer; the consumer of the ID-stage branch-taken signal (PCSrc) and the jump request.
- Holds the architectural fetch PC and selects the next PC: sequential, branch target or jump target.
- Generates the one-cycle IF/ID flush that squashes the wrong-path instruction.
- Captures a redirect that arrives while fetch cannot advance (instruction memory not ready) and replays it when fetch resumes.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/if_pc_next_sel.sv | 42 ++++
 rtl/if_pc_redirect.sv | 117 +++++++++++
 tb/tb_if_pc_redirect.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared constants and the state encoding for the IF-stage PC
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int unsigned PC_WIDTH          = 32;
    localparam logic [31:0] RESET_PC          = 32'h0000_0000;
    localparam logic [31:0] c_WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } pc_state_e;

endpackage
`default_nettype wire

// File: rtl/if_pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module      : if_pc_next_sel
// Description : Next-PC priority select (pending > jump > branch > PC+4);
//               all redirect targets are forced to word alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module if_pc_next_sel
    import pipeline_pkg::*;
#(
    parameter int unsigned PC_WIDTH = pipeline_pkg::PC_WIDTH
) (
    input  logic                i_pending_sel,
    input  logic [PC_WIDTH-1:0] i_pending_target,
    input  logic                i_jump,
    input  logic [PC_WIDTH-1:0] i_jump_target,
    input  logic                i_branch,
    input  logic [PC_WIDTH-1:0] i_branch_target,
    input  logic [PC_WIDTH-1:0] i_pc_plus4,
    output logic                o_req,
    output logic [PC_WIDTH-1:0] o_req_target,
    output logic [PC_WIDTH-1:0] o_next_pc
);

    localparam logic [PC_WIDTH-1:0] c_ALIGN_MASK =
        {{(PC_WIDTH-2){1'b1}}, c_WORD_ALIGN_MASK[1:0]};

    always_comb begin
        o_req        = i_jump | i_branch;
        o_req_target = (i_jump ? i_jump_target : i_branch_target) & c_ALIGN_MASK;
        o_next_pc    = i_pc_plus4;
        // A held redirect belongs to the stalled ID instruction, so it beats
        // whatever the ID-stage signals show now.
        if (i_pending_sel) begin
            o_next_pc = i_pending_target & c_ALIGN_MASK;
        end else if (o_req) begin
            o_next_pc = o_req_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_pc_redirect.sv
`default_nettype none
// ============================================================================
// Module      : if_pc_redirect
// Description : IF-stage PC sequencer with IF/ID flush generation and replay
//               of redirects that arrive while fetch is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module if_pc_redirect
    import pipeline_pkg::*;
#(
    parameter int unsigned          PC_WIDTH  = pipeline_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = PC_WIDTH'(pipeline_pkg::RESET_PC),
    parameter int unsigned          CNT_WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 PCSrc_ID,
    input  logic [PC_WIDTH-1:0]  Branch_Target_ID,
    input  logic                 Jump_ID,
    input  logic [PC_WIDTH-1:0]  Jump_Target_ID,
    input  logic                 PCWrite,
    input  logic                 Imem_Ready,
    output logic [PC_WIDTH-1:0]  PC_IF,
    output logic [PC_WIDTH-1:0]  PC_Plus4_IF,
    output logic                 Fetch_Valid_IF,
    output logic                 IF_Flush,
    output logic                 Redirect_Pending,
    output logic [CNT_WIDTH-1:0] Redirect_Count
);

    pc_state_e             r_state;
    pc_state_e             w_state_next;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_pending_target;
    logic [PC_WIDTH-1:0]   w_pc_plus4;
    logic [PC_WIDTH-1:0]   w_next_pc;
    logic [PC_WIDTH-1:0]   w_req_target;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  w_advance;
    logic                  w_req;
    logic                  w_hold;
    logic                  w_apply;

    assign w_pc_plus4 = r_pc + PC_WIDTH'(4);
    assign w_advance  = PCWrite & Imem_Ready;
    assign w_hold     = (r_state == ST_HOLD);

    if_pc_next_sel #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_sel (
        .i_pending_sel    (w_hold),
        .i_pending_target (r_pending_target),
        .i_jump           (Jump_ID),
        .i_jump_target    (Jump_Target_ID),
        .i_branch         (PCSrc_ID),
        .i_branch_target  (Branch_Target_ID),
        .i_pc_plus4       (w_pc_plus4),
        .o_req            (w_req),
        .o_req_target     (w_req_target),
        .o_next_pc        (w_next_pc)
    );

    // w_apply marks the cycle a redirect actually lands in PC_IF.
    always_comb begin
        w_state_next = r_state;
        w_apply      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_advance) begin
                    w_apply = w_req;
                end else if (w_req) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_advance) begin
                    w_apply      = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
        if (Reset) begin
            w_apply      = 1'b0;
            w_state_next = ST_RUN;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state          <= ST_RUN;
            r_pc             <= RESET_PC;
            r_pending_target <= '0;
            r_count          <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_advance) begin
                r_pc <= w_next_pc;
            end
            if (!w_hold && !w_advance && w_req) begin
                r_pending_target <= w_req_target;
            end
            if (w_apply && (r_count != '1)) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

    assign PC_IF            = r_pc;
    assign PC_Plus4_IF      = w_pc_plus4;
    assign IF_Flush         = w_apply;
    assign Fetch_Valid_IF   = w_advance & ~w_apply & ~Reset;
    assign Redirect_Pending = w_hold;
    assign Redirect_Count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_if_pc_redirect.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_pc_redirect
// Description : Vector-table bench for if_pc_redirect with a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_pc_redirect;

    localparam int unsigned c_CNT_W = 4;

    typedef struct {
        logic               rst;
        logic               pcsrc;
        logic [31:0]        btgt;
        logic               jump;
        logic [31:0]        jtgt;
        logic               pcwrite;
        logic               ready;
        logic               e_flush;
        logic               e_valid;
        logic [31:0]        e_pc;
        logic               e_pend;
        logic [c_CNT_W-1:0] e_cnt;
    } vec_t;

    logic               clk = 1'b0;
    logic               r_reset = 1'b1;
    logic               r_pcsrc = 1'b0;
    logic [31:0]        r_btgt = '0;
    logic               r_jump = 1'b0;
    logic [31:0]        r_jtgt = '0;
    logic               r_pcwrite = 1'b0;
    logic               r_ready = 1'b0;
    logic [31:0]        w_pc;
    logic [31:0]        w_pc_plus4;
    logic               w_valid;
    logic               w_flush;
    logic               w_pend;
    logic [c_CNT_W-1:0] w_cnt;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    if_pc_redirect #(
        .PC_WIDTH  (32),
        .RESET_PC  (32'h0000_0000),
        .CNT_WIDTH (c_CNT_W)
    ) dut (
        .Clk              (clk),
        .Reset            (r_reset),
        .PCSrc_ID         (r_pcsrc),
        .Branch_Target_ID (r_btgt),
        .Jump_ID          (r_jump),
        .Jump_Target_ID   (r_jtgt),
        .PCWrite          (r_pcwrite),
        .Imem_Ready       (r_ready),
        .PC_IF            (w_pc),
        .PC_Plus4_IF      (w_pc_plus4),
        .Fetch_Valid_IF   (w_valid),
        .IF_Flush         (w_flush),
        .Redirect_Pending (w_pend),
        .Redirect_Count   (w_cnt)
    );

    function automatic vec_t mk(input logic rst, input logic pcsrc, input logic [31:0] btgt,
                                input logic jump, input logic [31:0] jtgt,
                                input logic pcwrite, input logic ready,
                                input logic e_flush, input logic e_valid,
                                input logic [31:0] e_pc, input logic e_pend,
                                input logic [c_CNT_W-1:0] e_cnt);
        vec_t v;
        v.rst = rst;         v.pcsrc = pcsrc;     v.btgt = btgt;
        v.jump = jump;       v.jtgt = jtgt;       v.pcwrite = pcwrite;
        v.ready = ready;     v.e_flush = e_flush; v.e_valid = e_valid;
        v.e_pc = e_pc;       v.e_pend = e_pend;   v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle: combinational outputs are checked mid-cycle, the
    // registered results are popped from the scoreboard after the edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        r_reset   = v.rst;
        r_pcsrc   = v.pcsrc;
        r_btgt    = v.btgt;
        r_jump    = v.jump;
        r_jtgt    = v.jtgt;
        r_pcwrite = v.pcwrite;
        r_ready   = v.ready;
        #2;
        check({tag, "_if_flush"}, 32'(w_flush), 32'(v.e_flush));
        check({tag, "_fetch_valid"}, 32'(w_valid), 32'(v.e_valid));
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard actual=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_pc_if"}, w_pc, e.e_pc);
            check({tag, "_pc_plus4"}, w_pc_plus4, e.e_pc + 32'd4);
            check({tag, "_pending"}, 32'(w_pend), 32'(e.e_pend));
            check({tag, "_count"}, 32'(w_cnt), 32'(e.e_cnt));
        end
    endtask

    initial begin
        // rst pcsrc btgt jump jtgt pw rdy | flush valid pc pend cnt
        vecs.push_back(mk(1, 1, 32'h40,  1, 32'h80,  1, 1,  0, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   1, 1,  0, 1, 32'h4,   0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   1, 1,  0, 1, 32'h8,   0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   1, 1,  0, 1, 32'hC,   0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   1, 1,  0, 1, 32'h10,  0, 0));
        vecs.push_back(mk(0, 1, 32'h40,  0, 32'h0,   1, 1,  1, 0, 32'h40,  0, 1));
        vecs.push_back(mk(0, 1, 32'h80,  1, 32'h100, 1, 1,  1, 0, 32'h100, 0, 2));
        vecs.push_back(mk(0, 1, 32'h200, 0, 32'h0,   1, 0,  0, 0, 32'h100, 1, 2));
        vecs.push_back(mk(0, 1, 32'h300, 0, 32'h0,   1, 0,  0, 0, 32'h100, 1, 2));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   0, 0,  0, 0, 32'h100, 1, 2));
        vecs.push_back(mk(0, 1, 32'h300, 0, 32'h0,   1, 1,  1, 0, 32'h200, 0, 3));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   1, 1,  0, 1, 32'h204, 0, 3));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   0, 1,  0, 0, 32'h204, 0, 3));
        vecs.push_back(mk(0, 0, 32'h0,   1, 32'h43,  0, 1,  0, 0, 32'h204, 1, 3));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   1, 1,  1, 0, 32'h40,  0, 4));
        vecs.push_back(mk(0, 1, 32'h43,  0, 32'h0,   1, 1,  1, 0, 32'h40,  0, 5));
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFF, 0, 32'h0, 1, 1, 1, 0, 32'hFFFF_FFFC, 0, 6));
        vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,   1, 1,  0, 1, 32'h0,   0, 6));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while a redirect is held: the pending target must never land.
        apply(mk(0, 1, 32'h500, 0, 32'h0, 1, 0, 0, 0, 32'h0, 1, 6), "hold_enter");
        apply(mk(1, 0, 32'h0,   0, 32'h0, 1, 1, 0, 0, 32'h0, 0, 0), "hold_reset");
        apply(mk(0, 0, 32'h0,   0, 32'h0, 1, 1, 0, 1, 32'h4, 0, 0), "post_reset");

        // Counter saturation: redirect repeatedly past the all-ones value.
        for (int k = 1; k <= 18; k++) begin
            logic [c_CNT_W-1:0] exp_cnt;
            exp_cnt = (k >= 15) ? {c_CNT_W{1'b1}} : c_CNT_W'(k);
            apply(mk(0, 1, 32'h8, 0, 32'h0, 1, 1, 1, 0, 32'h8, 0, exp_cnt),
                  $sformatf("sat%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
